wb_bram_arbiter: RTL

WB_BRAM_ARBITER -- requirements
Module: wb_bram_arbiter

---
 rtl/wb_bram_arbiter_if.sv | 37 +++
 rtl/wb_bram_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bram_arbiter_if.sv
// Bus bundle for wb_bram_arbiter: a Wishbone slave port (port A) and a simple
// request/acknowledge port (port B). Both share one BRAM behind the arbiter.
// The slave modport is the arbiter side; the master modport is the requester side.
interface wb_bram_arbiter_if;
  // Wishbone port A
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  // Request/acknowledge port B
  logic        b_req;
  logic        b_we;
  logic [3:0]  b_wstrb;
  logic [31:0] b_addr;
  logic [31:0] b_wdata;
  logic        b_ack;
  logic [31:0] b_rdata;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    input  b_req, b_we, b_wstrb, b_addr, b_wdata,
    output b_ack, b_rdata
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    output b_req, b_we, b_wstrb, b_addr, b_wdata,
    input  b_ack, b_rdata
  );
endinterface

// File: rtl/wb_bram_arbiter.sv
// wb_bram_arbiter: shares one single-port BRAM between a Wishbone slave
// (port A, address-decoded on adr[31:20]) and a request/ack port B.
// Each access holds the RAM enabled for DELAYS+1 cycles, writes only in the
// first of those cycles, then captures ram_do and pulses the port's ack.
// Wishbone strobes outside the decoded window are acknowledged with zero data.
// Optional build macro BRAM_ARB_RR_EN: round-robin between simultaneous
// requests (A first after reset); without it port A has fixed priority.
// All outputs are registered; rst is synchronous and active-high.
module wb_bram_arbiter #(
  parameter int unsigned  DELAYS = 10,
  parameter logic [11:0]  DECODE = 12'h380
) (
  input  logic             clk,
  input  logic             rst,
  wb_bram_arbiter_if.slave bus,
  output logic             ram_en,
  output logic [3:0]       ram_we,
  output logic [31:0]      ram_addr,
  output logic [31:0]      ram_di,
  input  logic [31:0]      ram_do,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACC_A  = 3'd1,
    ACC_B  = 3'd2,
    DONE_A = 3'd3,
    DONE_B = 3'd4,
    MISS   = 3'd5
  } state_t;

  // Last wait-state count; the capture happens on the edge after it.
  localparam logic [3:0] LAST_CNT = 4'(DELAYS);

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic [31:0] addr_r, addr_s;
  logic [31:0] di_r, di_s;
  logic [3:0]  strb_r, strb_s;

  logic        ram_en_r, ram_en_s;
  logic [3:0]  ram_we_r, ram_we_s;
  logic [31:0] ram_addr_r, ram_addr_s;
  logic [31:0] ram_di_r, ram_di_s;
  logic        wbs_ack_r, wbs_ack_s;
  logic [31:0] wbs_dat_r, wbs_dat_s;
  logic        b_ack_r, b_ack_s;
  logic [31:0] b_rdata_r, b_rdata_s;
  logic        busy_r, busy_s;

  logic        wb_strobe_s;
  logic        req_a_s;
  logic        req_b_s;
  logic        miss_s;
  logic        grant_a_s;
  logic        grant_b_s;

  assign wb_strobe_s = bus.wbs_cyc_i & bus.wbs_stb_i;
  assign req_a_s     = wb_strobe_s & (bus.wbs_adr_i[31:20] == DECODE);
  assign miss_s      = wb_strobe_s & (bus.wbs_adr_i[31:20] != DECODE);
  assign req_b_s     = bus.b_req;

`ifdef BRAM_ARB_RR_EN
  // 1 = port B won the most recent contested grant (A goes first after reset)
  logic last_b_r, last_b_s;

  // Flip the last-grant flag only when both ports competed in IDLE
  always_comb begin
    if ((state_r == IDLE) && req_a_s && req_b_s) begin
      last_b_s = ~last_b_r;
    end else begin
      last_b_s = last_b_r;
    end
  end

  // Last-grant register
  always_ff @(posedge clk) begin
    if (rst) begin
      last_b_r <= 1'b1;
    end else begin
      last_b_r <= last_b_s;
    end
  end

  assign grant_a_s = req_a_s & (~req_b_s | last_b_r);
`else
  assign grant_a_s = req_a_s;
`endif

  assign grant_b_s = req_b_s & ~grant_a_s;

  // Next-state, wait counter and captured request fields
  always_comb begin
    state_s = state_r;
    cnt_s   = 4'd0;
    addr_s  = addr_r;
    di_s    = di_r;
    strb_s  = strb_r;
    case (state_r)
      IDLE: begin
        if (grant_a_s) begin
          state_s = ACC_A;
          addr_s  = bus.wbs_adr_i;
          di_s    = bus.wbs_dat_i;
          strb_s  = bus.wbs_sel_i & {4{bus.wbs_we_i}};
        end else if (grant_b_s) begin
          state_s = ACC_B;
          addr_s  = bus.b_addr;
          di_s    = bus.b_wdata;
          strb_s  = bus.b_wstrb & {4{bus.b_we}};
        end else if (miss_s) begin
          state_s = MISS;
        end else begin
          state_s = IDLE;
        end
      end
      ACC_A: begin
        // Wishbone master gave up the cycle: leave without acknowledging.
        if (!bus.wbs_cyc_i) begin
          state_s = IDLE;
        end else if (cnt_r == LAST_CNT) begin
          state_s = DONE_A;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      ACC_B: begin
        if (cnt_r == LAST_CNT) begin
          state_s = DONE_B;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      DONE_A:  state_s = IDLE;
      DONE_B:  state_s = IDLE;
      MISS:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output values for the coming cycle, decoded from the next state
  always_comb begin
    ram_en_s   = 1'b0;
    ram_we_s   = 4'd0;
    ram_addr_s = 32'd0;
    ram_di_s   = 32'd0;
    wbs_ack_s  = 1'b0;
    wbs_dat_s  = 32'd0;
    b_ack_s    = 1'b0;
    b_rdata_s  = 32'd0;
    busy_s     = (state_s != IDLE);
    case (state_s)
      ACC_A, ACC_B: begin
        ram_en_s   = 1'b1;
        ram_addr_s = addr_s;
        ram_di_s   = di_s;
        // Write strobes only in the first access cycle; the rest are reads
        // that let the captured word reflect the completed write.
        if (cnt_s == 4'd0) begin
          ram_we_s = strb_s;
        end else begin
          ram_we_s = 4'd0;
        end
      end
      DONE_A: begin
        wbs_ack_s = 1'b1;
        wbs_dat_s = ram_do;
      end
      DONE_B: begin
        b_ack_s   = 1'b1;
        b_rdata_s = ram_do;
      end
      MISS: begin
        wbs_ack_s = 1'b1;
      end
      default: begin
        ram_en_s = 1'b0;
      end
    endcase
  end

  // State, counter, request fields and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      addr_r     <= 32'd0;
      di_r       <= 32'd0;
      strb_r     <= 4'd0;
      ram_en_r   <= 1'b0;
      ram_we_r   <= 4'd0;
      ram_addr_r <= 32'd0;
      ram_di_r   <= 32'd0;
      wbs_ack_r  <= 1'b0;
      wbs_dat_r  <= 32'd0;
      b_ack_r    <= 1'b0;
      b_rdata_r  <= 32'd0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      addr_r     <= addr_s;
      di_r       <= di_s;
      strb_r     <= strb_s;
      ram_en_r   <= ram_en_s;
      ram_we_r   <= ram_we_s;
      ram_addr_r <= ram_addr_s;
      ram_di_r   <= ram_di_s;
      wbs_ack_r  <= wbs_ack_s;
      wbs_dat_r  <= wbs_dat_s;
      b_ack_r    <= b_ack_s;
      b_rdata_r  <= b_rdata_s;
      busy_r     <= busy_s;
    end
  end

  assign ram_en        = ram_en_r;
  assign ram_we        = ram_we_r;
  assign ram_addr      = ram_addr_r;
  assign ram_di        = ram_di_r;
  assign bus.wbs_ack_o = wbs_ack_r;
  assign bus.wbs_dat_o = wbs_dat_r;
  assign bus.b_ack     = b_ack_r;
  assign bus.b_rdata   = b_rdata_r;
  assign busy          = busy_r;

endmodule
